// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared bus widths, word size and DMA state encoding.
package mem_bus_pkg;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 11;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [ADDR_W-1:0] word_off(input logic [LEN_W-1:0] i);
        return ADDR_W'(i) * ADDR_W'(WORD_BYTES);
    endfunction
endpackage

// File: rtl/mem_dma_agen.sv
// mem_dma_agen: word index counter with src/dst address adders and terminal count.
module mem_dma_agen
    import mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  cnt,
    output logic [ADDR_W-1:0] rd_next,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] wr_next,
    output logic              last
);
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, idx, idx_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx   <= '0;
        end else if (load) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= cnt;
            idx   <= '0;
        end else if (inc) begin
            idx <= idx_p1;
        end
    end

    // Sums wrap naturally at 2^32, so crossing 0xFFFFFFFC is not an error.
    assign idx_p1  = idx + 1'b1;
    assign rd_next = src_q + word_off(idx_p1);
    assign wr_addr = dst_q + word_off(idx);
    assign wr_next = dst_q + word_off(idx_p1);
    assign last    = (idx == len_q - 1'b1);
endmodule

// File: rtl/mem_dma.sv
// mem_dma: single-channel word copy engine over a shared tristate memory bus.
// Optional MEM_DMA_FILL_EN adds a fill mode writing a constant at one word per cycle.
module mem_dma
    import mem_bus_pkg::*;
#(
    parameter int MAX_LEN = 1024
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef MEM_DMA_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);
    state_t            state;
    logic [DATA_W-1:0] word_q;
    logic              fill_q, fill_req, bad, zero, load, inc, last;
    logic [DATA_W-1:0] fill_val;
    logic [ADDR_W-1:0] rd_next, wr_addr, wr_next;

`ifdef MEM_DMA_FILL_EN
    assign fill_req = fill;
    assign fill_val = fill_data;
`else
    assign fill_req = 1'b0;
    assign fill_val = '0;
`endif

    assign bad  = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00) || (len > LEN_W'(MAX_LEN));
    assign zero = (len == '0);
    assign load = (state == IDLE) && start && !bad && !zero;
    assign inc  = (state == WR) && !last;

    // The bus is driven exactly while the write strobe is up, i.e. only in WR.
    assign mem_data = mem_we ? word_q : 'z;

    mem_dma_agen u_agen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .inc     (inc),
        .src     (src_addr),
        .dst     (dst_addr),
        .cnt     (len),
        .rd_next (rd_next),
        .wr_addr (wr_addr),
        .wr_next (wr_next),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            word_q   <= '0;
            fill_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy   <= 1'b1;
                    err    <= bad;
                    fill_q <= fill_req;
                    if (bad || zero) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (fill_req) begin
                        state    <= WR;
                        mem_we   <= 1'b1;
                        mem_addr <= dst_addr;
                        word_q   <= fill_val;
                    end else begin
                        state    <= RD;
                        mem_addr <= src_addr;
                    end
                end
                RD: begin
                    state    <= WR;
                    word_q   <= mem_data;
                    mem_we   <= 1'b1;
                    mem_addr <= wr_addr;
                end
                WR: if (last) begin
                    state    <= DONE;
                    done     <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                end else if (fill_q) begin
                    mem_addr <= wr_next;
                end else begin
                    state    <= RD;
                    mem_we   <= 1'b0;
                    mem_addr <= rd_next;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
